// File: rtl/solution_frame_tx_if.sv
// Byte-stream link from the solution frame transmitter toward the host bridge.
// The master drives data/valid and the slave returns ready.
interface solution_frame_tx_if;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (output tx_data_o, output tx_valid_o, input tx_ready_i);
    modport slave  (input tx_data_o, input tx_valid_o, output tx_ready_i);
endinterface

// File: rtl/solution_frame_tx.sv
// Captures the best-solution tracker outputs on eval_done_i and streams them as
// a fixed frame: A5, p0, d0, d1, d2, fx (MSB byte first), XOR checksum.
module solution_frame_tx #(
    parameter int pd = 12,
    parameter int p  = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 eval_done_i,
    input  logic [pd+p-1:0]      d0_sol_i,
    input  logic [pd+p-1:0]      d1_sol_i,
    input  logic [pd+p-1:0]      d2_sol_i,
    input  logic [3+p-1:0]       fx_best_i,
    input  logic [7:0]           p0_idx_best_i,
    solution_frame_tx_if.master  tx,
    output logic                 busy_o,
    output logic                 overrun_o,
    input  logic                 clr_ovr_i,
    output logic [15:0]          frame_cnt_o
);
    localparam int DW = pd + p;
    localparam int FW = 3 + p;
    localparam int DB = (DW + 7) / 8;
    localparam int FB = (FW + 7) / 8;
    localparam int NB = 1 + 3 * DB + FB;   // body bytes between header and checksum
    localparam int IW = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_CSUM = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [7:0]    csum;
    logic [7:0]    tx_data;
    logic          tx_valid;

    logic [DW-1:0] d0_q, d1_q, d2_q;
    logic [FW-1:0] fx_q;
    logic [7:0]    p0_q;

    logic [8*NB-1:0] body_vec;
    logic [7:0]      body_b [NB];
    logic            hs;
    logic [IW-1:0]   idx_nxt;
    logic [7:0]      csum_nxt;

    assign body_vec = {p0_q, (8*DB)'(d0_q), (8*DB)'(d1_q), (8*DB)'(d2_q), (8*FB)'(fx_q)};

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            body_b[i] = body_vec[(NB-1-i)*8 +: 8];
        end
    end

    assign hs       = tx_valid & tx.tx_ready_i;
    assign idx_nxt  = idx + IW'(1);
    assign csum_nxt = csum ^ tx_data;

    assign tx.tx_data_o  = tx_data;
    assign tx.tx_valid_o = tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            csum        <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            busy_o      <= 1'b0;
            overrun_o   <= 1'b0;
            frame_cnt_o <= '0;
            d0_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            fx_q        <= '0;
            p0_q        <= '0;
        end else begin
            // A pulse that cannot be captured marks overrun; set beats clear.
            if (eval_done_i && state != S_IDLE) overrun_o <= 1'b1;
            else if (clr_ovr_i)                 overrun_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (eval_done_i) begin
                        d0_q     <= d0_sol_i;
                        d1_q     <= d1_sol_i;
                        d2_q     <= d2_sol_i;
                        fx_q     <= fx_best_i;
                        p0_q     <= p0_idx_best_i;
                        csum     <= '0;
                        idx      <= '0;
                        tx_data  <= 8'hA5;
                        tx_valid <= 1'b1;
                        busy_o   <= 1'b1;
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (hs) begin
                        tx_data <= body_b[0];
                        idx     <= '0;
                        state   <= S_BODY;
                    end
                end
                S_BODY: begin
                    if (hs) begin
                        csum <= csum_nxt;
                        if (idx == IW'(NB-1)) begin
                            tx_data <= csum_nxt;
                            state   <= S_CSUM;
                        end else begin
                            idx     <= idx_nxt;
                            tx_data <= body_b[idx_nxt];
                        end
                    end
                end
                S_CSUM: begin
                    if (hs) begin
                        tx_data     <= '0;
                        tx_valid    <= 1'b0;
                        busy_o      <= 1'b0;
                        frame_cnt_o <= frame_cnt_o + 16'd1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_solution_frame_tx.sv
// Scoreboard bench for solution_frame_tx: expected frames are queued at the
// capture pulse and popped on each accepted byte.
module tb_solution_frame_tx;
    localparam int PD = 12;
    localparam int P  = 22;
    localparam int DW = PD + P;
    localparam int FW = 3 + P;
    localparam int DB = (DW + 7) / 8;
    localparam int FB = (FW + 7) / 8;
    localparam int N  = 3 + 3 * DB + FB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          eval_done = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0;
    logic [FW-1:0] fx = '0;
    logic [7:0]    p0 = '0;
    logic          busy, overrun, clr_ovr = 1'b0;
    logic [15:0]   frame_cnt;

    solution_frame_tx_if txif ();

    solution_frame_tx #(.pd(PD), .p(P)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .eval_done_i   (eval_done),
        .d0_sol_i      (d0),
        .d1_sol_i      (d1),
        .d2_sol_i      (d2),
        .fx_best_i     (fx),
        .p0_idx_best_i (p0),
        .tx            (txif.master),
        .busy_o        (busy),
        .overrun_o     (overrun),
        .clr_ovr_i     (clr_ovr),
        .frame_cnt_o   (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_cnt = '0;
    logic [7:0]  sb [$];

    task automatic push_field(input logic [63:0] v, input int nbytes, inout logic [7:0] cs);
        logic [7:0] b;
        for (int i = nbytes - 1; i >= 0; i--) begin
            b = 8'(v >> (8 * i));
            sb.push_back(b);
            cs = cs ^ b;
        end
    endtask

    task automatic push_frame(input logic [7:0] ip0, input logic [63:0] id0, input logic [63:0] id1,
                              input logic [63:0] id2, input logic [63:0] ifx);
        logic [7:0] cs;
        cs = 8'h00;
        sb.push_back(8'hA5);
        push_field({56'd0, ip0}, 1, cs);
        push_field(id0, DB, cs);
        push_field(id1, DB, cs);
        push_field(id2, DB, cs);
        push_field(ifx, FB, cs);
        sb.push_back(cs);
    endtask

    // Called at a negedge; returns at the negedge right after the capture edge.
    task automatic pulse(input logic [7:0] ip0, input logic [63:0] id0, input logic [63:0] id1,
                         input logic [63:0] id2, input logic [63:0] ifx);
        p0 = ip0; d0 = DW'(id0); d1 = DW'(id1); d2 = DW'(id2); fx = FW'(ifx);
        eval_done = 1'b1;
        push_frame(ip0, id0, id1, id2, ifx);
        @(negedge clk);
        eval_done = 1'b0;
    endtask

    // Consumes bytes until the scoreboard empties; optional backpressure and an
    // extra eval_done (optionally with clr_ovr) injected when byte inj_at is on the bus.
    task automatic drain(input bit bp, input int budget, input int inj_at, input bit inj_clr);
        int cyc, stall, got;
        bit hold, injected;
        logic [7:0] held, expb;
        cyc = 0; stall = 0; got = 0; hold = 0; injected = 0; held = '0;
        while (sb.size() > 0 && cyc < budget) begin
            eval_done = 1'b0;
            clr_ovr   = 1'b0;
            if (!injected && got == inj_at) begin
                injected  = 1;
                eval_done = 1'b1;
                clr_ovr   = inj_clr;
                p0 = 8'h5A; d0 = DW'(64'h1234); d1 = DW'(64'h5678); d2 = DW'(64'h9ABC); fx = FW'(64'hDEF);
            end
            if (bp) begin
                if (stall > 0) begin txif.tx_ready_i = 1'b0; stall--; end
                else if ($urandom_range(0, 3) == 0) begin txif.tx_ready_i = 1'b0; stall = 4; end
                else txif.tx_ready_i = 1'b1;
            end else begin
                txif.tx_ready_i = 1'b1;
                total++;
                if (txif.tx_valid_o !== 1'b1) begin
                    bad++; $display("FAIL bubble: byte %0d valid=%b required 1", got, txif.tx_valid_o);
                end
            end
            if (hold) begin
                total++;
                if (txif.tx_valid_o !== 1'b1 || txif.tx_data_o !== held) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%b data=%02h required valid=1 data=%02h",
                             txif.tx_valid_o, txif.tx_data_o, held);
                end
            end
            if (txif.tx_valid_o && txif.tx_ready_i) begin
                expb = sb.pop_front();
                total++;
                if (txif.tx_data_o !== expb) begin
                    bad++; $display("FAIL byte[%0d]: got %02h required %02h", got, txif.tx_data_o, expb);
                end
                got++;
                hold = 0;
            end else begin
                hold = txif.tx_valid_o;
                held = txif.tx_data_o;
            end
            @(negedge clk);
            cyc++;
        end
        eval_done = 1'b0;
        clr_ovr   = 1'b0;
        txif.tx_ready_i = 1'b1;
        if (sb.size() > 0) begin
            total++; bad++;
            $display("FAIL timeout: %0d bytes left after %0d cycles, required 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic check_done();
        total++;
        if (busy !== 1'b0 || txif.tx_valid_o !== 1'b0) begin
            bad++; $display("FAIL frame_end: busy=%b valid=%b required 0 0", busy, txif.tx_valid_o);
        end
        total++;
        if (frame_cnt !== exp_cnt) begin
            bad++; $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        txif.tx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (txif.tx_valid_o !== 1'b0 || txif.tx_data_o !== 8'h00) begin
            bad++; $display("FAIL reset_tx: valid=%b data=%02h required 0 00", txif.tx_valid_o, txif.tx_data_o);
        end
        total++;
        if (busy !== 1'b0 || overrun !== 1'b0 || frame_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_status: busy=%b ovr=%b cnt=%0d required 0 0 0", busy, overrun, frame_cnt);
        end
        rst_n = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pulse(8'h03, 64'd1, 64'd2, 64'd3, 64'd4);
        total++;
        if (txif.tx_valid_o !== 1'b1 || txif.tx_data_o !== 8'hA5 || busy !== 1'b1) begin
            bad++; $display("FAIL latency: valid=%b data=%02h busy=%b required 1 a5 1",
                            txif.tx_valid_o, txif.tx_data_o, busy);
        end
        drain(1'b0, 100, -1, 1'b0);
        exp_cnt++;
        check_done();
    endtask

    task automatic test_backpressure();
        pulse(8'h03, 64'd1, 64'd2, 64'd3, 64'd4);
        drain(1'b1, 600, -1, 1'b0);
        exp_cnt++;
        check_done();
    endtask

    task automatic test_zero_extend();
        pulse(8'hC3, 64'h3_FFFF_FFFF, 64'h2_8000_0001, 64'h0_0F0F_F0F0, 64'h1FF_FFFF);
        drain(1'b0, 100, -1, 1'b0);
        exp_cnt++;
        check_done();
    endtask

    task automatic test_overrun();
        pulse(8'h11, 64'hAB, 64'hCD, 64'hEF, 64'h77);
        drain(1'b0, 100, 10, 1'b0);
        exp_cnt++;
        check_done();
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set: got %b required 1", overrun);
        end
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_clr: got %b required 0", overrun);
        end
        pulse(8'h22, 64'h1, 64'h10, 64'h100, 64'h1000);
        drain(1'b0, 100, 3, 1'b1);
        exp_cnt++;
        check_done();
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set_wins: got %b required 1", overrun);
        end
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse(8'h44, 64'h2_0000_0000, 64'h3, 64'h4, 64'h5);
        drain(1'b0, 100, -1, 1'b0);
        exp_cnt++;
        check_done();
        // Still in the first IDLE cycle after the checksum handshake.
        pulse(8'h55, 64'h6, 64'h7, 64'h8, 64'h9);
        total++;
        if (txif.tx_valid_o !== 1'b1 || txif.tx_data_o !== 8'hA5) begin
            bad++; $display("FAIL b2b_start: valid=%b data=%02h required 1 a5", txif.tx_valid_o, txif.tx_data_o);
        end
        drain(1'b0, 100, -1, 1'b0);
        exp_cnt++;
        check_done();
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL b2b_overrun: got %b required 0", overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b7;
        pulse(8'h66, 64'h1_2345_6789, 64'hA, 64'hB, 64'hC);
        b7 = sb[7];
        txif.tx_ready_i = 1'b1;
        repeat (7) @(negedge clk);
        total++;
        if (txif.tx_data_o !== b7) begin
            bad++; $display("FAIL mid_byte7: got %02h required %02h", txif.tx_data_o, b7);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (txif.tx_valid_o !== 1'b0 || txif.tx_data_o !== 8'h00 || busy !== 1'b0 ||
            overrun !== 1'b0 || frame_cnt !== 16'd0) begin
            bad++; $display("FAIL async_reset: valid=%b data=%02h busy=%b ovr=%b cnt=%0d required all 0",
                            txif.tx_valid_o, txif.tx_data_o, busy, overrun, frame_cnt);
        end
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(8'h77, 64'h3_0000_0001, 64'h1_FFFF_0000, 64'h42, 64'h1AB_CDEF);
        drain(1'b0, 100, -1, 1'b0);
        exp_cnt++;
        check_done();
    endtask

    initial begin
        txif.tx_ready_i = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_extend();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
